// File: rtl/lc_ctrl_pkg.sv
// rtl/lc_ctrl_pkg.sv - shared types and constants for the life-cycle transition controller
package lc_ctrl_pkg;

  localparam int unsigned STATE_W     = 6;
  localparam int unsigned NUM_TARGETS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PROG,
    ST_DONE,
    ST_ERROR
  } lc_fsm_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_NOT_IN_TABLE = 2'd1,
    ERR_NOT_INCR     = 2'd2,
    ERR_TIMEOUT      = 2'd3
  } err_code_e;

  // Entry k of the table sits in bits [k*STATE_W +: STATE_W].
  typedef logic [NUM_TARGETS-1:0][STATE_W-1:0] ext_dec_lc_state_t;

  localparam ext_dec_lc_state_t DEFAULT_TARGETS = {6'h04, 6'h03, 6'h02, 6'h01, 6'h00};

endpackage

// File: rtl/lc_transition_ctrl.sv
// rtl/lc_transition_ctrl.sv - life-cycle transition sequencer: table scan, program handshake, commit/error
//   clk_i, rst_i        : clock, synchronous active-high reset
//   allowed_targets_i   : packed legal-target table, held static while busy
//   req_valid_i/_ready_o: transition request handshake, req_target_i is the requested state
//   prog_valid_o/ack_i  : program handshake to the state datapath, prog_state_o is the target
//   cur_state_o         : committed current state
//   done_o/error_o      : one-cycle completion pulses, err_code_o holds the last failure reason
module lc_transition_ctrl #(
  parameter int unsigned NUM_TARGETS = 5,
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned WAIT_MAX    = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_TARGETS*STATE_W-1:0] allowed_targets_i,
  input  logic                           req_valid_i,
  input  logic [STATE_W-1:0]             req_target_i,
  output logic                           req_ready_o,
  output logic                           prog_valid_o,
  output logic [STATE_W-1:0]             prog_state_o,
  input  logic                           prog_ack_i,
  output logic [STATE_W-1:0]             cur_state_o,
  output logic                           done_o,
  output logic                           error_o,
  output logic [1:0]                     err_code_o
);
  import lc_ctrl_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_TARGETS + 1);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  lc_fsm_e            state_q;
  logic [STATE_W-1:0] tgt_q;
  logic [STATE_W-1:0] cur_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  err_code_e          err_q;
  logic [STATE_W-1:0] entry;

  assign entry        = allowed_targets_i[idx_q*STATE_W +: STATE_W];
  assign req_ready_o  = (state_q == ST_IDLE);
  assign prog_state_o = tgt_q;
  assign cur_state_o  = cur_q;
  assign err_code_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      tgt_q        <= '0;
      cur_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= ERR_NONE;
      prog_valid_o <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            tgt_q   <= req_target_i;
            idx_q   <= '0;
            err_q   <= ERR_NONE;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // First matching entry decides; later duplicates are never reached.
          if (entry == tgt_q) begin
            if (tgt_q > cur_q) begin
              cnt_q        <= '0;
              prog_valid_o <= 1'b1;
              state_q      <= ST_PROG;
            end else begin
              err_q   <= ERR_NOT_INCR;
              error_o <= 1'b1;
              state_q <= ST_ERROR;
            end
          end else if (idx_q == IDX_W'(NUM_TARGETS - 1)) begin
            err_q   <= ERR_NOT_IN_TABLE;
            error_o <= 1'b1;
            state_q <= ST_ERROR;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_PROG: begin
          // Ack is tested before the timeout so an ack in the last cycle still commits.
          if (prog_ack_i) begin
            cur_q        <= tgt_q;
            prog_valid_o <= 1'b0;
            done_o       <= 1'b1;
            state_q      <= ST_DONE;
          end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
            prog_valid_o <= 1'b0;
            err_q        <= ERR_TIMEOUT;
            error_o      <= 1'b1;
            state_q      <= ST_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// tb/tb_lc_transition_ctrl.sv - self-checking bench for lc_transition_ctrl
module tb_lc_transition_ctrl;
  import lc_ctrl_pkg::*;

  logic                       clk_i = 1'b0;
  logic                       rst_i = 1'b1;
  logic [NUM_TARGETS*STATE_W-1:0] allowed_targets_i;
  logic                       req_valid_i = 1'b0;
  logic [STATE_W-1:0]         req_target_i = '0;
  logic                       req_ready_o;
  logic                       prog_valid_o;
  logic [STATE_W-1:0]         prog_state_o;
  logic                       prog_ack_i = 1'b0;
  logic [STATE_W-1:0]         cur_state_o;
  logic                       done_o;
  logic                       error_o;
  logic [1:0]                 err_code_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lc_transition_ctrl #(.NUM_TARGETS(5), .STATE_W(6), .WAIT_MAX(8)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .allowed_targets_i (allowed_targets_i),
    .req_valid_i       (req_valid_i),
    .req_target_i      (req_target_i),
    .req_ready_o       (req_ready_o),
    .prog_valid_o      (prog_valid_o),
    .prog_state_o      (prog_state_o),
    .prog_ack_i        (prog_ack_i),
    .cur_state_o       (cur_state_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .err_code_o        (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           rst_first;
    logic [5:0]   tgt;
    int           ack_m;       // PROG cycle (1-based) to ack in, 0 = never
    int           exp_pv_first;
    int           exp_pv_len;
    int           exp_done;
    int           exp_err;
    int           exp_code;
    int           exp_cur;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // Called at #1 after an edge with the DUT in IDLE. Cycle numbers follow the
  // acceptance edge = end of cycle 0. Returns with the DUT back in IDLE.
  task automatic run_req(input logic [5:0] t, input int ack_m,
                         output int pv_first, output int pv_len,
                         output int done_cyc, output int err_cyc,
                         output int bad_state, output int busy_ready);
    int cyc;
    int prog_n;
    pv_first = -1; pv_len = 0; done_cyc = -1; err_cyc = -1;
    bad_state = 0; busy_ready = 0; prog_n = 0;
    req_valid_i  = 1'b1;
    req_target_i = t;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cyc = 1;
    while (cyc < 40 && done_cyc < 0 && err_cyc < 0) begin
      if (req_ready_o) busy_ready++;
      if (prog_valid_o) begin
        if (pv_first < 0) pv_first = cyc;
        pv_len++;
        prog_n++;
        if (prog_state_o != t) bad_state++;
      end
      if (done_o) done_cyc = cyc;
      if (error_o) err_cyc = cyc;
      // Without a planned ack, ack is held high outside PROG to show it is ignored.
      if (ack_m == 0) prog_ack_i = !prog_valid_o;
      else            prog_ack_i = prog_valid_o && (prog_n == ack_m);
      @(posedge clk_i); #1;
      cyc++;
    end
    prog_ack_i = 1'b0;
    if (done_cyc < 0 && err_cyc < 0) chk("completion_timeout", cyc, 0);
  endtask

  initial begin
    int pf, pl, dc, ec, bs, br;
    allowed_targets_i = DEFAULT_TARGETS;

    //            rst  tgt    ack pvf pvl done err code cur
    vecs[0] = '{1'b0, 6'h03, 2,  5,  2,  7,  -1, 0,   3};
    vecs[1] = '{1'b0, 6'h02, 0, -1,  0, -1,   4, 2,   3};
    vecs[2] = '{1'b0, 6'h3F, 0, -1,  0, -1,   6, 1,   3};
    vecs[3] = '{1'b1, 6'h01, 0,  3,  8, -1,  11, 3,   0};
    vecs[4] = '{1'b0, 6'h04, 8,  6,  8, 14,  -1, 0,   4};
    vecs[5] = '{1'b0, 6'h04, 0, -1,  0, -1,   6, 2,   4};
    vecs[6] = '{1'b1, 6'h00, 0, -1,  0, -1,   2, 2,   0};

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    chk("rst_ready",      int'(req_ready_o),  1);
    chk("rst_cur",        int'(cur_state_o),  0);
    chk("rst_prog_state", int'(prog_state_o), 0);
    chk("rst_err_code",   int'(err_code_o),   0);
    chk("rst_prog_valid", int'(prog_valid_o), 0);
    chk("rst_pulses",     int'({done_o, error_o}), 0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_req(vecs[i].tgt, vecs[i].ack_m, pf, pl, dc, ec, bs, br);
      chk($sformatf("v%0d_pv_first", i),  pf, vecs[i].exp_pv_first);
      chk($sformatf("v%0d_pv_len", i),    pl, vecs[i].exp_pv_len);
      chk($sformatf("v%0d_done", i),      dc, vecs[i].exp_done);
      chk($sformatf("v%0d_error", i),     ec, vecs[i].exp_err);
      chk($sformatf("v%0d_err_code", i),  int'(err_code_o),  vecs[i].exp_code);
      chk($sformatf("v%0d_cur", i),       int'(cur_state_o), vecs[i].exp_cur);
      chk($sformatf("v%0d_prog_state", i), bs, 0);
      chk($sformatf("v%0d_busy_ready", i), br, 0);
      chk($sformatf("v%0d_idle_ready", i), int'(req_ready_o), 1);
    end

    // Reset in the 3rd PROG cycle abandons the transition and clears cur_state.
    do_reset();
    run_req(6'h01, 1, pf, pl, dc, ec, bs, br);
    chk("pre_done", dc, 4);
    chk("pre_cur",  int'(cur_state_o), 1);
    req_valid_i  = 1'b1;
    req_target_i = 6'h03;
    @(posedge clk_i); #1;              // cycle 1
    req_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;                                // cycle 6, 2nd PROG cycle
    chk("mid_prog_valid", int'(prog_valid_o), 1);
    @(posedge clk_i); #1;              // cycle 7, 3rd PROG cycle
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_ready",      int'(req_ready_o),  1);
    chk("abort_cur",        int'(cur_state_o),  0);
    chk("abort_prog_valid", int'(prog_valid_o), 0);
    chk("abort_pulses",     int'({done_o, error_o}), 0);
    begin
      int pulses = 0;
      repeat (3) begin
        @(posedge clk_i); #1;
        if (done_o || error_o || !req_ready_o) pulses++;
      end
      chk("abort_quiet", pulses, 0);
    end
    run_req(6'h01, 1, pf, pl, dc, ec, bs, br);
    chk("post_pv_first", pf, 3);
    chk("post_done",     dc, 4);
    chk("post_error",    ec, -1);
    chk("post_cur",      int'(cur_state_o), 1);
    chk("post_err_code", int'(err_code_o),  0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
